// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared widths, operation/state encodings and helpers for the
// iterative multiply/divide unit (mdu_ctrl, mdu_step).
package mdu_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DLEN  = 64;
    localparam int unsigned CNT_W = 6;

    // Operation encodings
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [CNT_W-1:0] MDU_ITERS = CNT_W'(32);

    typedef enum logic [2:0] {
        MDU_S_IDLE = 3'd0,
        MDU_S_PREP = 3'd1,
        MDU_S_CALC = 3'd2,
        MDU_S_FIX  = 3'd3,
        MDU_S_DONE = 3'd4
    } mdu_state_e;

    // Request captured on an accepted start strobe
    typedef struct packed {
        logic [1:0]      op;
        logic [XLEN-1:0] num1;
        logic [XLEN-1:0] num2;
    } mdu_req_t;

    // Magnitude of v when interpreted as signed (sgn=1), else v unchanged
    function automatic logic [XLEN-1:0] mdu_abs(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration of the multiply/divide loop.
//   acc_i     : 64-bit working accumulator
//   operand_i : multiplicand (multiply) or divisor magnitude (divide)
//   div_i     : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o     : next accumulator (divide: quotient LSB left at 0)
//   qbit_o    : quotient bit produced by a divide step (0 for multiply)
module mdu_step
    import mdu_ctrl_pkg::*;
(
    input  logic [DLEN-1:0] acc_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic            div_i,
    output logic [DLEN-1:0] acc_o,
    output logic            qbit_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;

    // Multiply: add into upper half with carry, then shift the whole 65-bit
    // value right. Divide: shift {rem, quot} left, then trial-subtract.
    always_comb begin
        acc_o  = '0;
        qbit_o = 1'b0;
        sum    = {1'b0, acc_i[DLEN-1:XLEN]}
               + (acc_i[0] ? {1'b0, operand_i} : (XLEN+1)'(0));
        rem_sh = acc_i[DLEN-1:XLEN-1];
        diff   = {1'b0, rem_sh} - {2'b00, operand_i};
        if (div_i) begin
            qbit_o = ~diff[XLEN+1];
            acc_o  = {(qbit_o ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                      acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o  = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Build option: MDU_EARLY_OUT_EN - multiply leaves CALC once the remaining
// multiplier bits are zero (results unchanged, divide always 32 steps).
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : request strobe (IDLE only) and operation
//   num1, num2      : rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we, lo_we    : MTHI/MTLO enables with data wdata (IDLE/DONE only)
//   busy            : operation in flight (PREP..FIX)
//   done            : one-cycle pulse when HI/LO hold a new result
//   hi, lo          : architectural HI/LO registers
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_e       state_q, state_d;
    mdu_req_t         req_q, req_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [DLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_div;
    logic             op_signed;
    logic [CNT_W-1:0] cnt_dec;
    logic [DLEN-1:0]  step_acc;
    logic             step_qbit;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [DLEN-1:0]  prod;
    logic [DLEN-1:0]  prod_fix;
`ifdef MDU_EARLY_OUT_EN
    logic [XLEN-1:0]  rem_mask;
    logic             mul_empty;
`endif

    assign op_div    = req_q.op[1];
    assign op_signed = ~req_q.op[0];
    assign cnt_dec   = cnt_q - CNT_W'(1);

    mdu_step u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .div_i     (op_div),
        .acc_o     (step_acc),
        .qbit_o    (step_qbit)
    );

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_a    = mdu_abs(req_q.num1, op_signed);
        mag_b    = mdu_abs(req_q.num2, op_signed);
`ifdef MDU_EARLY_OUT_EN
        rem_mask  = '0;
        mul_empty = 1'b0;
        // Early exit leaves unconsumed multiplier bits at the bottom
        prod      = acc_q >> cnt_q;
`else
        prod      = acc_q;
`endif
        prod_fix = neg_q ? (~prod + DLEN'(1)) : prod;

        case (state_q)
            MDU_S_IDLE: begin
                if (start) begin
                    req_d   = '{op: op, num1: num1, num2: num2};
                    state_d = MDU_S_PREP;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            MDU_S_PREP: begin
                if (op_div) begin
                    acc_d  = {XLEN'(0), mag_a};
                    opnd_d = mag_b;
                end else begin
                    acc_d  = {XLEN'(0), mag_b};
                    opnd_d = mag_a;
                end
                neg_d   = op_signed & (req_q.num1[XLEN-1] ^ req_q.num2[XLEN-1]);
                rneg_d  = op_signed & req_q.num1[XLEN-1];
                dz_d    = op_div & (req_q.num2 == XLEN'(0));
                cnt_d   = MDU_ITERS;
                state_d = MDU_S_CALC;
            end
            MDU_S_CALC: begin
                acc_d = step_acc | DLEN'(step_qbit);
                cnt_d = cnt_dec;
                if (cnt_dec == CNT_W'(0)) state_d = MDU_S_FIX;
`ifdef MDU_EARLY_OUT_EN
                // Remaining multiplier bits sit in acc_d[cnt_dec-1:0]
                rem_mask  = XLEN'((DLEN'(1) << cnt_dec) - DLEN'(1));
                mul_empty = !op_div && ((acc_d[XLEN-1:0] & rem_mask) == XLEN'(0));
                if (mul_empty) state_d = MDU_S_FIX;
`endif
            end
            MDU_S_FIX: begin
                if (!op_div) begin
                    hi_d = prod_fix[DLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end else if (dz_q) begin
                    hi_d = req_q.num1;
                    lo_d = '1;
                end else begin
                    hi_d = rneg_q ? -acc_q[DLEN-1:XLEN] : acc_q[DLEN-1:XLEN];
                    lo_d = neg_q  ? -acc_q[XLEN-1:0]    : acc_q[XLEN-1:0];
                end
                state_d = MDU_S_DONE;
            end
            MDU_S_DONE: begin
                if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
                state_d = MDU_S_IDLE;
            end
            default: state_d = MDU_S_IDLE;
        endcase

        busy_d = (state_d == MDU_S_PREP) || (state_d == MDU_S_CALC) || (state_d == MDU_S_FIX);
        done_d = (state_d == MDU_S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_S_IDLE;
            req_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against an
// arithmetic reference model (64-bit products, signed/unsigned divide).
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .num1  (num1),
        .num2  (num2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: architectural result and start-to-done latency in cycles
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, m;
        int          k;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 35;
        p   = '0;
        if (o == MDU_MULT || o == MDU_MULTU) begin
            if (o == MDU_MULT) p = 64'(sa * sb);
            else               p = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
`ifdef MDU_EARLY_OUT_EN
            m = (o == MDU_MULT && sb < 0) ? 64'(-sb) : {32'd0, b};
            k = 0;
            while (m != 0) begin
                m = m >> 1;
                k++;
            end
            if (k == 0) k = 1;
            lat = 3 + k;
`else
            m = '0;
            k = 0;
`endif
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (o == MDU_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end else begin
            eh = a % b;
            el = a / b;
        end
    endtask

    // Issue one op, wait for done (bounded), check timing and result.
    // poke: pulse start/hi_we/lo_we mid-CALC; mt_start: lo_we with start.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke, input bit mt_start);
        logic [31:0] eh, el;
        int          lat, n, busy_low;
        model(o, a, b, eh, el, lat);
        start = 1'b1; op = o; num1 = a; num2 = b;
        if (mt_start) begin
            lo_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        tick();
        start = 1'b0; lo_we = 1'b0;
        if (mt_start) check({name, "/mt_dropped"}, {32'd0, lo}, {32'd0, exp_lo});
        n = 1;
        busy_low = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_low++;
            if (poke && n == 10) begin
                start = 1'b1; op = ~o; num1 = $urandom; num2 = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end
            tick();
            n++;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        end
        check({name, "/latency"}, 64'(n), 64'(lat));
        check({name, "/busy_in_flight"}, 64'(busy_low), 64'd0);
        check({name, "/busy_at_done"}, {63'd0, busy}, 64'd0);
        check({name, "/hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, "/lo"}, {32'd0, lo}, {32'd0, el});
        exp_hi = eh;
        exp_lo = el;
        tick();
        check({name, "/done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; op = '0; num1 = '0; num2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) tick();
        check("reset/busy", {63'd0, busy}, 64'd0);
        check("reset/done", {63'd0, done}, 64'd0);
        check("reset/hi", {32'd0, hi}, 64'd0);
        check("reset/lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        tick();

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        run_op("multu_big", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        run_op("multu_by1", MDU_MULTU, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        run_op("divu_zero", MDU_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0);
        run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("divu_poke", MDU_DIVU, 32'hCAFE_F00D, 32'h0000_1234, 1'b1, 1'b0);

        // MTLO in IDLE lands on the next cycle; HI untouched
        lo_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        lo_we = 1'b0;
        exp_lo = 32'h1234_5678;
        check("mtlo/lo", {32'd0, lo}, {32'd0, exp_lo});
        check("mtlo/hi", {32'd0, hi}, {32'd0, exp_hi});
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        tick();
        hi_we = 1'b0;
        exp_hi = 32'h0BAD_F00D;
        check("mthi/hi", {32'd0, hi}, {32'd0, exp_hi});

        run_op("mt_with_start", MDU_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);

        // Reset in the middle of a divide abandons it
        start = 1'b1; op = MDU_DIV; num1 = 32'h7654_3210; num2 = 32'd9;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst/busy", {63'd0, busy}, 64'd0);
        check("midrst/hi", {32'd0, hi}, 64'd0);
        check("midrst/lo", {32'd0, lo}, 64'd0);
        dcnt = 0;
        repeat (40) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        check("midrst/no_done", 64'(dcnt), 64'd0);
        run_op("multu_3x5", MDU_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
